rm_len_hdr: RTL and testbench

- Receive-side inverse of the IOQ length-header insertion block; sits at the output-queue egress before the MAC/CPU transmit path.
- Strips the IOQ module-header word (ctrl == STAGE_NUMBER) from each packet and passes all other words through unchanged.
- Buffers words in a small internal FIFO so in_rdy is registered.
- Optionally checks the header's byte/word lengths against the counted payload.

---
 rtl/rm_len_hdr.sv | 190 +++++++++++++++++++
 tb/tb_rm_len_hdr.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rm_len_hdr.sv
// rm_len_hdr: strips the IOQ module-header word (ctrl == STAGE_NUMBER) from each
// packet at the output-queue egress. All other words pass through a small FIFO
// unchanged, so in_rdy comes straight from a register.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_ctrl     input word and its ctrl byte lanes
//   in_wr / in_rdy      input write strobe / registered ready
//   out_data/out_ctrl   FIFO head (don't-care while out_wr = 0)
//   out_wr / out_rdy    output write strobe / downstream ready
//   len_err             one-cycle pulse on a header length mismatch
//   len_err_cnt         saturating count of mismatched packets
//
// Build option: define RM_HDR_LEN_CHECK_EN to compare the stripped header's
// byte/word lengths against the forwarded payload. Without it, len_err and
// len_err_cnt are tied to zero and no length logic is built.
module rm_len_hdr #(
    parameter int unsigned           DATA_WIDTH   = 64,
    parameter int unsigned           CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] STAGE_NUMBER = 'hff,
    parameter int unsigned           FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  len_err,
    output logic [15:0]           len_err_cnt
);

    localparam int unsigned   PtrW   = $clog2(FIFO_DEPTH);
    // Ready while the occupancy after this edge leaves room for two more words.
    localparam logic [PtrW:0] RdyMax = (PtrW + 1)'(FIFO_DEPTH - 2);

    typedef enum logic [0:0] {StHdr, StPayload} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CTRL_WIDTH-1:0] mem_ctrl [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q, count_d;
    logic                  in_rdy_q;
    logic                  push, pop;
    logic                  strip, first, body, last;

    assign pop      = out_rdy && (count_q != '0);
    assign out_wr   = pop;
    assign out_data = mem_data[rd_ptr_q];
    assign out_ctrl = mem_ctrl[rd_ptr_q];
    assign in_rdy   = in_rdy_q;

    // Framing: the state only moves on an accepted input word.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        strip   = 1'b0;
        first   = 1'b0;
        body    = 1'b0;
        last    = 1'b0;
        if (in_wr) begin
            unique case (state_q)
                StHdr: begin
                    if (in_ctrl == STAGE_NUMBER) begin
                        strip = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (in_ctrl == '0) begin
                            first   = 1'b1;
                            state_d = StPayload;
                        end
                    end
                end
                StPayload: begin
                    push = 1'b1;
                    if (in_ctrl == '0) begin
                        body = 1'b1;
                    end else begin
                        last    = 1'b1;
                        state_d = StHdr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= in_data;
            mem_ctrl[wr_ptr_q] <= in_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StHdr;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            in_rdy_q <= (count_d <= RdyMax);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef RM_HDR_LEN_CHECK_EN
    logic [15:0] byte_len_q, word_len_q, byte_cnt_q, word_cnt_q, len_err_cnt_q;
    logic        hdr_valid_q, len_err_q;
    logic [15:0] last_bytes, final_bytes, final_words;
    logic        mismatch;

    // One-hot ctrl bit i marks the last valid byte lane: CTRL_WIDTH - i bytes.
    // Anything that is not one-hot counts as a full word.
    always_comb begin
        last_bytes = 16'(CTRL_WIDTH);
        if ($onehot(in_ctrl)) begin
            for (int i = 0; i < CTRL_WIDTH; i++) begin
                if (in_ctrl[i]) last_bytes = 16'(CTRL_WIDTH - i);
            end
        end
    end

    assign final_words = word_cnt_q + 16'd1;
    assign final_bytes = byte_cnt_q + last_bytes;
    assign mismatch    = hdr_valid_q &&
                         ((final_bytes != byte_len_q) || (final_words != word_len_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_len_q    <= '0;
            word_len_q    <= '0;
            byte_cnt_q    <= '0;
            word_cnt_q    <= '0;
            hdr_valid_q   <= 1'b0;
            len_err_q     <= 1'b0;
            len_err_cnt_q <= '0;
        end else begin
            len_err_q <= 1'b0;
            if (strip) begin
                hdr_valid_q <= 1'b1;
                byte_len_q  <= in_data[15:0];
                word_len_q  <= in_data[47:32];
            end
            if (first) begin
                word_cnt_q <= 16'd1;
                byte_cnt_q <= 16'(CTRL_WIDTH);
            end else if (body) begin
                word_cnt_q <= word_cnt_q + 16'd1;
                byte_cnt_q <= byte_cnt_q + 16'(CTRL_WIDTH);
            end
            if (last) begin
                hdr_valid_q <= 1'b0;
                len_err_q   <= mismatch;
                if (mismatch && (len_err_cnt_q != 16'hffff)) begin
                    len_err_cnt_q <= len_err_cnt_q + 16'd1;
                end
            end
        end
    end

    assign len_err     = len_err_q;
    assign len_err_cnt = len_err_cnt_q;
`else
    logic unused_len_sigs;
    assign unused_len_sigs = ^{strip, first, body, last};
    assign len_err         = 1'b0;
    assign len_err_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_rm_len_hdr.sv
module tb_rm_len_hdr;

    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic          in_wr, in_rdy, out_wr, out_rdy, len_err;
    logic [15:0]   len_err_cnt;

    always #5 clk = ~clk;

    rm_len_hdr dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .out_wr      (out_wr),
        .out_rdy     (out_rdy),
        .len_err     (len_err),
        .len_err_cnt (len_err_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: expected FIFO contents and per-packet length bookkeeping.
    logic [71:0] mq[$];
    logic [71:0] stim[$];
    logic [71:0] out_log[$];
    bit          m_in_pkt, m_hdr_valid;
    int          m_words, m_bytes;
    logic [15:0] m_blen, m_wlen;
    bit          exp_in_rdy, exp_len_err;
    int          exp_cnt;
    bit          chk_en = 1'b0;
    int          err_pulses = 0;

`ifdef RM_HDR_LEN_CHECK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int last_bytes(logic [7:0] c);
        case (c)
            8'h01: return 8;
            8'h02: return 7;
            8'h04: return 6;
            8'h08: return 5;
            8'h10: return 4;
            8'h20: return 3;
            8'h40: return 2;
            8'h80: return 1;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_in_pkt    = 0;
        m_hdr_valid = 0;
        exp_in_rdy  = 0;
        exp_len_err = 0;
        exp_cnt     = 0;
    endtask

    // Applies the inputs that were present at the clock edge just taken.
    task automatic model_edge();
        bit mism;
        exp_len_err = 0;
        if (out_rdy && mq.size() > 0) void'(mq.pop_front());
        if (in_wr) begin
            if (!m_in_pkt && in_ctrl == 8'hff) begin
                m_hdr_valid = 1;
                m_blen      = in_data[15:0];
                m_wlen      = in_data[47:32];
            end else begin
                mq.push_back({in_ctrl, in_data});
                if (!m_in_pkt) begin
                    if (in_ctrl == 8'h00) begin
                        m_in_pkt = 1;
                        m_words  = 1;
                        m_bytes  = 8;
                    end
                end else if (in_ctrl == 8'h00) begin
                    m_words += 1;
                    m_bytes += 8;
                end else begin
                    m_words += 1;
                    m_bytes += last_bytes(in_ctrl);
                    mism = m_hdr_valid &&
                           (16'(m_words) != m_wlen || 16'(m_bytes) != m_blen);
                    if (LenChk && mism) begin
                        exp_len_err = 1;
                        if (exp_cnt < 65535) exp_cnt++;
                    end
                    m_hdr_valid = 0;
                    m_in_pkt    = 0;
                end
            end
        end
        exp_in_rdy = (mq.size() <= DEPTH - 2);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_rdy", in_rdy, exp_in_rdy);
            check("out_wr", out_wr, out_rdy && mq.size() > 0);
            if (out_wr && mq.size() > 0) begin
                check("out_word", {out_ctrl, out_data}, mq[0]);
                out_log.push_back({out_ctrl, out_data});
            end
            check("len_err", len_err, exp_len_err);
            check("len_err_cnt", len_err_cnt, 16'(exp_cnt));
            if (len_err) err_pulses++;
        end
    end

    always @(posedge clk) begin
        if (!reset && in_wr && !in_rdy) begin
            errors++;
            $display("FAIL in_wr_while_not_ready at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic run_stream(int rdy_pct, int wr_pct, int budget);
        int cyc = 0;
        while (stim.size() > 0 && cyc < budget) begin
            out_rdy = ($urandom_range(99) < rdy_pct);
            if (exp_in_rdy && $urandom_range(99) < wr_pct) begin
                {in_ctrl, in_data} = stim.pop_front();
                in_wr = 1'b1;
            end else begin
                in_wr = 1'b0;
            end
            step();
            cyc++;
        end
        in_wr = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        in_wr   = 1'b0;
        out_rdy = 1'b1;
        while (mq.size() > 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        check("drained", 32'(mq.size()), 0);
    endtask

    task automatic gen_pkt(int n_ff, bit bad, bit other);
        int          n;
        logic [7:0]  lc;
        logic [15:0] wl, bl;
        logic [63:0] d;
        n  = $urandom_range(1, 6);
        lc = ($urandom_range(1) == 1) ? 8'(1 << $urandom_range(7)) : 8'($urandom_range(1, 255));
        wl = 16'(n + 1);
        bl = 16'(8 * n + last_bytes(lc));
        if (bad) begin
            if ($urandom_range(1) == 1) bl = bl + 16'd1;
            else                        wl = wl + 16'd1;
        end
        for (int i = 0; i < n_ff; i++) begin
            d = {$urandom, $urandom};
            if (i == n_ff - 1) begin
                d[47:32] = wl;
                d[15:0]  = bl;
            end
            stim.push_back({8'hff, d});
        end
        if (other) stim.push_back({8'($urandom_range(1, 254)), $urandom, $urandom});
        for (int i = 0; i < n; i++) stim.push_back({8'h00, $urandom, $urandom});
        stim.push_back({lc, $urandom, $urandom});
    endtask

    // Header ff, seven ctrl-0 payload words, last word ctrl 0x10 (4 bytes).
    task automatic directed_pkt(logic [15:0] blen);
        stim.push_back({8'hff, 16'h0, 16'd8, 16'h0, blen});
        for (int i = 0; i < 7; i++) stim.push_back({8'h00, 64'h1000_0000_0000_0000 + 64'(i)});
        stim.push_back({8'h10, 64'h1000_0000_0000_0007});
    endtask

    logic [71:0] w;

    initial begin
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_rdy", in_rdy, 0);
        check("reset_out_wr", out_wr, 0);
        check("reset_len_err", len_err, 0);
        check("reset_len_err_cnt", len_err_cnt, 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step();
        check("in_rdy_after_reset", in_rdy, 1);

        // Matching header: 8 words out, no error.
        out_log.delete();
        err_pulses = 0;
        directed_pkt(16'd60);
        run_stream(100, 100, 200);
        drain();
        check("t1_words", 32'(out_log.size()), 8);
        w = out_log[0];
        check("t1_first", w, {8'h00, 64'h1000_0000_0000_0000});
        w = out_log[7];
        check("t1_last", w, {8'h10, 64'h1000_0000_0000_0007});
        check("t1_pulses", 32'(err_pulses), 0);

        // Wrong byte length: one pulse, counter 1 when checking is built in.
        out_log.delete();
        err_pulses = 0;
        directed_pkt(16'd64);
        run_stream(100, 100, 200);
        drain();
        check("t2_words", 32'(out_log.size()), 8);
        check("t2_pulses", 32'(err_pulses), LenChk ? 1 : 0);
        check("t2_cnt", len_err_cnt, LenChk ? 1 : 0);

        // ff then another module header 0x40: the 0x40 word leads the output.
        out_log.delete();
        stim.push_back({8'hff, 16'h0, 16'd4, 16'h0, 16'd32});
        stim.push_back({8'h40, 64'hAAAA_0000_0000_0040});
        for (int i = 0; i < 3; i++) stim.push_back({8'h00, 64'hBBBB_0000_0000_0000 + 64'(i)});
        stim.push_back({8'h01, 64'hCCCC_0000_0000_0001});
        run_stream(100, 100, 200);
        drain();
        check("t3_words", 32'(out_log.size()), 5);
        w = out_log[0];
        check("t3_first", w, {8'h40, 64'hAAAA_0000_0000_0040});

        // Backpressure: in_rdy falls with three words held, then drain in order.
        out_log.delete();
        for (int i = 0; i < 5; i++) stim.push_back({8'h00, 64'hD000_0000_0000_0000 + 64'(i)});
        stim.push_back({8'h02, 64'hD000_0000_0000_00FF});
        run_stream(0, 100, 10);
        check("t4_held", 32'(mq.size()), DEPTH - 1);
        check("t4_in_rdy_low", in_rdy, 0);
        run_stream(50, 100, 500);
        check("t4_stream_done", 32'(stim.size()), 0);
        drain();
        check("t4_words", 32'(out_log.size()), 6);

        // No ff header: forwarded intact, counter unchanged.
        out_log.delete();
        err_pulses = 0;
        stim.push_back({8'h00, 64'hE000_0000_0000_0000});
        stim.push_back({8'h80, 64'hE000_0000_0000_0001});
        run_stream(100, 100, 100);
        drain();
        check("t5_words", 32'(out_log.size()), 2);
        check("t5_pulses", 32'(err_pulses), 0);
        check("t5_cnt", len_err_cnt, LenChk ? 1 : 0);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            gen_pkt($urandom_range(0, 2), ($urandom_range(3) == 0), $urandom_range(1) == 1);
            run_stream($urandom_range(30, 100), 75, 2000);
            check("rand_stream_done", 32'(stim.size()), 0);
        end
        drain();

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 6; i++) stim.push_back({8'h00, 64'hF000_0000_0000_0000 + 64'(i)});
        stim.push_back({8'h01, 64'hF000_0000_0000_00FF});
        run_stream(0, 100, 3);
        chk_en  = 1'b0;
        in_wr   = 1'b0;
        out_rdy = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_out_wr", out_wr, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_len_err_cnt", len_err_cnt, 0);
        stim.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        step();
        check("in_rdy_after_release", in_rdy, 1);
        out_log.delete();
        err_pulses = 0;
        directed_pkt(16'd64);
        run_stream(100, 100, 200);
        drain();
        check("t6_words", 32'(out_log.size()), 8);
        check("t6_pulses", 32'(err_pulses), LenChk ? 1 : 0);
        check("t6_cnt", len_err_cnt, LenChk ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
